// File: rtl/spi_page_prog_seq.sv
// Page-program sequencer for spi_cmd: buffers one page, then issues WREN, PP and READ STATUS polls.
// Optional poll timeout: define SPI_PROG_POLL_TIMEOUT_EN to bound polling at POLL_LIMIT and raise error.
module spi_page_prog_seq #(
    parameter int PAGE_BYTES = 256,
    parameter int POLL_LIMIT = 65535
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_valid,
    input  logic [7:0]    wr_data,
    output logic          wr_ready,
    input  logic [23:0]   addr,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [7:0]    status,
    output logic          cmd_trigger,
    input  logic          cmd_busy,
    output logic [8:0]    cmd_in_count,
    output logic          cmd_out_count,
    output logic [2079:0] cmd_data,
    input  logic [7:0]    cmd_rx,
    output logic          cmd_quad
);

    localparam int BUF_W   = 2048;
    localparam int FRAME_W = 2080;

    typedef enum logic [3:0] {
        IDLE,
        WREN_GO,
        WREN_WAIT,
        PP_GO,
        PP_WAIT,
        RS_GO,
        RS_WAIT,
        RS_CHECK,
        DONE
    } state_t;

    state_t             state;
    logic [8:0]         byte_cnt;
    logic [BUF_W-1:0]   buffer;
    logic [23:0]        addr_q;
    logic               seen;
    logic               byte_take;
    logic               start_take;
    logic [8:0]         cnt_next;
    logic [FRAME_W-1:0] pp_frame;
`ifdef SPI_PROG_POLL_TIMEOUT_EN
    logic [15:0]        poll_cnt;
`endif

    assign wr_ready   = (state == IDLE) && (byte_cnt < 9'(PAGE_BYTES));
    assign byte_take  = wr_valid && wr_ready;
    assign cnt_next   = byte_cnt + 9'(byte_take);
    // A byte arriving with start counts toward the page, so start sees the updated count.
    assign start_take = start && (state == IDLE) && (cnt_next != 9'd0);
    assign pp_frame   = (FRAME_W'({8'h02, addr_q}) << {byte_cnt, 3'b000}) | FRAME_W'(buffer);
    assign cmd_quad   = 1'b0;

`ifndef SPI_PROG_POLL_TIMEOUT_EN
    assign error = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            byte_cnt      <= 9'd0;
            buffer        <= '0;
            addr_q        <= 24'd0;
            seen          <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            status        <= 8'h00;
            cmd_trigger   <= 1'b0;
            cmd_in_count  <= 9'd0;
            cmd_out_count <= 1'b0;
            cmd_data      <= '0;
`ifdef SPI_PROG_POLL_TIMEOUT_EN
            poll_cnt      <= 16'd0;
            error         <= 1'b0;
`endif
        end else begin
            cmd_trigger <= 1'b0;
            done        <= 1'b0;
            case (state)
                IDLE: begin
                    if (byte_take) begin
                        buffer   <= {buffer[BUF_W-9:0], wr_data};
                        byte_cnt <= cnt_next;
                    end
                    if (start_take) begin
                        addr_q        <= addr;
                        busy          <= 1'b1;
                        cmd_data      <= FRAME_W'(8'h06);
                        cmd_in_count  <= 9'd1;
                        cmd_out_count <= 1'b0;
                        state         <= WREN_GO;
`ifdef SPI_PROG_POLL_TIMEOUT_EN
                        error         <= 1'b0;
                        poll_cnt      <= 16'd0;
`endif
                    end
                end
                WREN_GO: begin
                    if (!cmd_busy) begin
                        cmd_trigger <= 1'b1;
                        state       <= WREN_WAIT;
                    end
                end
                WREN_WAIT: begin
                    if (seen && !cmd_busy) begin
                        seen          <= 1'b0;
                        cmd_data      <= pp_frame;
                        cmd_in_count  <= byte_cnt + 9'd4;
                        cmd_out_count <= 1'b0;
                        state         <= PP_GO;
                    end else if (cmd_busy) begin
                        seen <= 1'b1;
                    end
                end
                PP_GO: begin
                    if (!cmd_busy) begin
                        cmd_trigger <= 1'b1;
                        state       <= PP_WAIT;
                    end
                end
                PP_WAIT: begin
                    if (seen && !cmd_busy) begin
                        seen          <= 1'b0;
                        cmd_data      <= FRAME_W'(8'h05);
                        cmd_in_count  <= 9'd1;
                        cmd_out_count <= 1'b1;
                        state         <= RS_GO;
                    end else if (cmd_busy) begin
                        seen <= 1'b1;
                    end
                end
                RS_GO: begin
                    if (!cmd_busy) begin
                        cmd_trigger <= 1'b1;
                        state       <= RS_WAIT;
                    end
                end
                RS_WAIT: begin
                    if (seen && !cmd_busy) begin
                        seen   <= 1'b0;
                        status <= cmd_rx;
`ifdef SPI_PROG_POLL_TIMEOUT_EN
                        poll_cnt <= poll_cnt + 16'd1;
`endif
                        state  <= RS_CHECK;
                    end else if (cmd_busy) begin
                        seen <= 1'b1;
                    end
                end
                RS_CHECK: begin
                    // WIP is bit 0 of the status register.
                    if (!status[0]) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end
`ifdef SPI_PROG_POLL_TIMEOUT_EN
                    else if (poll_cnt == 16'(POLL_LIMIT)) begin
                        error <= 1'b1;
                        done  <= 1'b1;
                        state <= DONE;
                    end
`endif
                    else begin
                        state <= RS_GO;
                    end
                end
                DONE: begin
                    byte_cnt <= 9'd0;
                    buffer   <= '0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_page_prog_seq.sv
// Directed bench for spi_page_prog_seq with a small spi_cmd responder that logs every transaction.
module tb_spi_page_prog_seq;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          wr_valid = 1'b0;
    logic [7:0]    wr_data = 8'h00;
    logic          wr_ready;
    logic [23:0]   addr = 24'h0;
    logic          start = 1'b0;
    logic          busy;
    logic          done;
    logic          error;
    logic [7:0]    status;
    logic          cmd_trigger;
    logic          cmd_busy = 1'b0;
    logic [8:0]    cmd_in_count;
    logic          cmd_out_count;
    logic [2079:0] cmd_data;
    logic [7:0]    cmd_rx = 8'h00;
    logic          cmd_quad;

    int total = 0;
    int bad = 0;

    spi_page_prog_seq #(.PAGE_BYTES(256), .POLL_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .addr(addr), .start(start),
        .busy(busy), .done(done), .error(error), .status(status),
        .cmd_trigger(cmd_trigger), .cmd_busy(cmd_busy),
        .cmd_in_count(cmd_in_count), .cmd_out_count(cmd_out_count),
        .cmd_data(cmd_data), .cmd_rx(cmd_rx), .cmd_quad(cmd_quad)
    );

    always #5 clk = ~clk;

    // spi_cmd responder: busy for three cycles per transaction, status from the WIP plan.
    int          trig_n = 0;
    int          rs_n = 0;
    int          wip_until = 0;
    int          proto_err = 0;
    logic        stall = 1'b0;
    logic        prev_trig = 1'b0;
    logic [3:0]  mcnt = 4'd0;
    logic [8:0]  log_in  [64];
    logic        log_out [64];
    logic [63:0] log_lo  [64];
    logic [7:0]  log_top [64];

    always @(posedge clk) begin
        prev_trig <= cmd_trigger;
        if (cmd_trigger && (prev_trig || cmd_busy)) proto_err <= proto_err + 1;
        if (cmd_trigger) begin
            log_in[trig_n[5:0]]  <= cmd_in_count;
            log_out[trig_n[5:0]] <= cmd_out_count;
            log_lo[trig_n[5:0]]  <= cmd_data[63:0];
            log_top[trig_n[5:0]] <= cmd_data[int'(cmd_in_count)*8-1 -: 8];
            trig_n <= trig_n + 1;
            if (cmd_out_count) begin
                cmd_rx <= (rs_n < wip_until) ? 8'h03 : 8'h00;
                rs_n   <= rs_n + 1;
            end
            cmd_busy <= 1'b1;
            mcnt     <= 4'd3;
        end else if (stall) begin
            cmd_busy <= 1'b1;
        end else if (mcnt != 4'd0) begin
            mcnt <= mcnt - 4'd1;
            if (mcnt == 4'd1) cmd_busy <= 1'b0;
        end else begin
            cmd_busy <= 1'b0;
        end
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic load_bytes(input logic [7:0] first, input int n, input logic [7:0] step);
        logic [7:0] b;
        b = first;
        for (int i = 0; i < n; i++) begin
            wr_valid = 1'b1;
            wr_data  = b;
            @(negedge clk);
            b = b + step;
        end
        wr_valid = 1'b0;
    endtask

    task automatic pulse_start(input logic [23:0] a);
        addr  = a;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int maxc);
        int n;
        n = 0;
        while (done !== 1'b1 && n < maxc) begin
            @(negedge clk);
            n++;
        end
        check_val(tag, 64'(done), 64'd1);
    endtask

    task automatic wait_trig(input string tag, input int target, input int maxc);
        int n;
        n = 0;
        while (trig_n < target && n < maxc) begin
            @(negedge clk);
            n++;
        end
        check_val(tag, 64'(trig_n >= target), 64'd1);
    endtask

    initial begin
        int base;
        // Reset state
        @(negedge clk);
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_done", 64'(done), 64'd0);
        check_val("rst_error", 64'(error), 64'd0);
        check_val("rst_status", 64'(status), 64'h00);
        check_val("rst_trig", 64'(cmd_trigger), 64'd0);
        check_val("rst_incnt", 64'(cmd_in_count), 64'd0);
        check_val("rst_outcnt", 64'(cmd_out_count), 64'd0);
        check_val("rst_data", 64'(|cmd_data), 64'd0);
        check_val("rst_quad", 64'(cmd_quad), 64'd0);
        check_val("rst_wr_ready", 64'(wr_ready), 64'd1);
        reset = 1'b1;
        @(negedge clk);

        // Rejected start with empty buffer
        base = trig_n;
        pulse_start(24'h000100);
        repeat (8) @(negedge clk);
        check_val("empty_start_busy", 64'(busy), 64'd0);
        check_val("empty_start_trig", 64'(trig_n - base), 64'd0);

        // Basic program: status 0x03 then 0x00
        base = trig_n;
        wip_until = rs_n + 1;
        load_bytes(8'hAA, 4, 8'h11);
        pulse_start(24'h012345);
        check_val("basic_busy", 64'(busy), 64'd1);
        wait_done("basic_done", 500);
        check_val("basic_err", 64'(error), 64'd0);
        check_val("basic_ntrig", 64'(trig_n - base), 64'd4);
        check_val("basic_wren_cnt", 64'(log_in[base]), 64'd1);
        check_val("basic_wren_data", log_lo[base], 64'h06);
        check_val("basic_pp_cnt", 64'(log_in[base+1]), 64'd8);
        check_val("basic_pp_out", 64'(log_out[base+1]), 64'd0);
        check_val("basic_pp_data", log_lo[base+1], 64'h02012345AABBCCDD);
        check_val("basic_rs1", {55'd0, log_out[base+2], log_lo[base+2][7:0]}, {55'd0, 1'b1, 8'h05});
        check_val("basic_rs2", {55'd0, log_out[base+3], log_lo[base+3][7:0]}, {55'd0, 1'b1, 8'h05});
        @(negedge clk);
        check_val("basic_done_once", 64'(done), 64'd0);
        check_val("basic_status", 64'(status), 64'h00);
        check_val("basic_wr_ready", 64'(wr_ready), 64'd1);
        check_val("basic_busy_end", 64'(busy), 64'd0);

        // Full page plus one extra byte
        base = trig_n;
        wip_until = rs_n;
        load_bytes(8'h00, 256, 8'h01);
        check_val("full_wr_ready", 64'(wr_ready), 64'd0);
        load_bytes(8'h55, 1, 8'h00);
        pulse_start(24'hABCDEF);
        wait_done("full_done", 800);
        check_val("full_pp_cnt", 64'(log_in[base+1]), 64'd260);
        check_val("full_pp_top", 64'(log_top[base+1]), 64'h02);
        check_val("full_pp_low", log_lo[base+1], 64'hF8F9FAFBFCFDFEFF);
        @(negedge clk);

`ifdef SPI_PROG_POLL_TIMEOUT_EN
        // WIP stuck: four polls then error with done
        base = trig_n;
        wip_until = 1000000;
        load_bytes(8'h5A, 1, 8'h00);
        pulse_start(24'h000000);
        wait_done("tmo_done", 800);
        check_val("tmo_error", 64'(error), 64'd1);
        check_val("tmo_ntrig", 64'(trig_n - base), 64'd6);
        @(negedge clk);
        check_val("tmo_sticky", 64'(error), 64'd1);
        wip_until = rs_n;
        load_bytes(8'h5B, 1, 8'h00);
        pulse_start(24'h000000);
        check_val("tmo_clear", 64'(error), 64'd0);
        wait_done("tmo_redo_done", 500);
        @(negedge clk);
`else
        // WIP held for five polls, polling continues until it clears
        base = trig_n;
        wip_until = rs_n + 5;
        load_bytes(8'h5A, 1, 8'h00);
        pulse_start(24'h000000);
        wait_done("poll_done", 1000);
        check_val("poll_error", 64'(error), 64'd0);
        check_val("poll_ntrig", 64'(trig_n - base), 64'd8);
        @(negedge clk);
`endif

        // Start pulsed during PP_WAIT is ignored
        base = trig_n;
        wip_until = rs_n;
        load_bytes(8'h10, 2, 8'h01);
        pulse_start(24'h000010);
        wait_trig("rej_pp_trig", base + 2, 100);
        check_val("rej_in_pp", 64'(busy), 64'd1);
        pulse_start(24'h000020);
        wait_done("rej_done", 500);
        repeat (10) @(negedge clk);
        check_val("rej_ntrig", 64'(trig_n - base), 64'd3);
        check_val("rej_busy", 64'(busy), 64'd0);

        // Reset during PP_WAIT
        base = trig_n;
        load_bytes(8'h20, 3, 8'h01);
        pulse_start(24'h000030);
        wait_trig("rstmid_pp_trig", base + 2, 100);
        reset = 1'b0;
        #1;
        check_val("rstmid_busy", 64'(busy), 64'd0);
        check_val("rstmid_trig", 64'(cmd_trigger), 64'd0);
        check_val("rstmid_incnt", 64'(cmd_in_count), 64'd0);
        check_val("rstmid_data", 64'(|cmd_data), 64'd0);
        check_val("rstmid_wr_ready", 64'(wr_ready), 64'd1);
        @(negedge clk);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        check_val("rstmid_ntrig", 64'(trig_n - base), 64'd2);
        pulse_start(24'h000040);
        repeat (4) @(negedge clk);
        check_val("rstmid_cnt_zero", 64'(busy), 64'd0);

        // cmd_busy held after start delays the first trigger
        base = trig_n;
        wip_until = rs_n;
        load_bytes(8'h77, 1, 8'h00);
        stall = 1'b1;
        pulse_start(24'h000050);
        repeat (3) @(negedge clk);
        check_val("stall_no_trig", 64'(trig_n - base), 64'd0);
        check_val("stall_trig_low", 64'(cmd_trigger), 64'd0);
        stall = 1'b0;
        @(negedge clk);
        check_val("stall_busy_fell", 64'(cmd_busy), 64'd0);
        check_val("stall_trig_wait", 64'(cmd_trigger), 64'd0);
        @(negedge clk);
        check_val("stall_trig_now", 64'(cmd_trigger), 64'd1);
        wait_done("stall_done", 500);
        @(negedge clk);

        check_val("protocol", 64'(proto_err), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_page_prog_seq.md
# spi_page_prog_seq

- Command sequencer directly upstream of the `spi_cmd` SPI transaction engine.
- Buffers up to one page of host write data and runs the full page-program sequence through `spi_cmd`, one transaction per step:
  1. WRITE ENABLE (0x06)
  2. PAGE PROGRAM (0x02 + 24-bit address + data)
  3. repeated READ STATUS (0x05) until WIP (bit 0) clears
- Reports completion, the last status byte and a poll-timeout error to the host.

## Interface
- `PAGE_BYTES`, default 256: page buffer depth in bytes (1..256).
- `POLL_LIMIT`, default 65535: maximum number of READ STATUS transactions per program (16-bit).
- `clk` in 1: single clock; all logic on rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `wr_valid` in 1: host byte valid.
- `wr_data` in 8: host byte.
- `wr_ready` out 1: buffer accepts a byte.
- `addr` in 24: flash address, sampled when `start` is accepted.
- `start` in 1: begin sequence.
- `busy` out 1: sequence in progress.
- `done` out 1: one-cycle completion pulse.
- `error` out 1: poll timeout; sticky.
- `status` out 8: last READ STATUS byte.
- `cmd_trigger` out 1: to `spi_cmd` trigger.
- `cmd_busy` in 1: from `spi_cmd` busy.
- `cmd_in_count` out 9: bytes to send.
- `cmd_out_count` out 1: bytes to read (0/1).
- `cmd_data` out 2080: transmit vector.
- `cmd_rx` in 8: `spi_cmd` data_out.
- `cmd_quad` out 1: tied 0.

## Operation
- Buffer load:
  - `wr_ready` = (state==IDLE) && (byte_cnt < PAGE_BYTES).
  - A byte is accepted when `wr_valid && wr_ready`: buffer shifts left 8 bits, new byte enters at [7:0], byte_cnt increments.
- Start acceptance:
  - `start` is accepted only in IDLE with byte_cnt > 0.
  - Otherwise it is ignored: start with an empty buffer, or start while busy.
  - On acceptance: latch `addr`, clear `error`, clear poll counter.
- States:
  - IDLE
  - WREN_GO → WREN_WAIT
  - PP_GO → PP_WAIT
  - RS_GO → RS_WAIT → RS_CHECK
  - DONE → IDLE
- `cmd_data` framing: first byte on the wire is at bits [cnt*8-1 -: 8], where cnt = `cmd_in_count`. Unused upper bits are 0.
  - WREN: count 1, out 0, [7:0]=0x06.
  - PP: count byte_cnt+4, out 0, `cmd_data` = ({0x02, addr} << byte_cnt*8) | buffer.
  - RS: count 1, out 1, [7:0]=0x05.
- `cmd_data`, `cmd_in_count` and `cmd_out_count` are held stable from entry to a *_GO state until exit from the matching *_WAIT state.
- *_GO state: when `cmd_busy`==0, register `cmd_trigger`=1 and move to *_WAIT.
- *_WAIT state:
  - Set `seen` on `cmd_busy`==1.
  - Exit when `seen` && `cmd_busy`==0.
  - Clear `seen` on exit.
- RS_WAIT exit: `status` ← `cmd_rx`, poll_cnt increments.
- RS_CHECK:
  - `status[0]`==0 → DONE.
  - Else, if poll_cnt==POLL_LIMIT and timeout is compiled in → set `error`, go to DONE.
  - Else → RS_GO.
- DONE: `done`=1 for one cycle, byte_cnt←0, → IDLE.

## Timing
- Reset values:
  - State IDLE, byte_cnt 0, `seen` 0.
  - `busy` 0, `done` 0, `error` 0, `status` 0x00.
  - `cmd_trigger` 0, `cmd_in_count` 0, `cmd_out_count` 0, `cmd_data` 0, `cmd_quad` 0.
  - `wr_ready` 1 (follows from IDLE with byte_cnt 0).
- `busy` is registered: high from the cycle after `start` is accepted through the DONE cycle, inclusive.
- `cmd_trigger`:
  - Exactly one cycle wide.
  - Visible in the first cycle of *_WAIT, while `cmd_busy` is still 0.
  - Earliest assertion is 2 edges after `start` is accepted.
- A *_GO state stalls indefinitely while `cmd_busy`=1. This covers `spi_cmd` holding busy after reset.
- Back-to-back transactions: minimum 1 idle cycle between `cmd_busy` falling and the next `cmd_trigger`.
- Simultaneous `wr_valid` and `start` in IDLE: the byte is accepted and included in the PP; the start uses the updated byte_cnt.
- Reset asserted mid-operation:
  - Immediate return to reset values; buffer contents discarded.
  - No transaction issued after reset until a new `start`.

## Configuration
- `SPI_PROG_POLL_TIMEOUT_EN` defined: poll counter and limit compare implemented; `error` raised after POLL_LIMIT polls with WIP still set.
- `SPI_PROG_POLL_TIMEOUT_EN` undefined: polling continues until WIP clears; `error` constant 0; no poll counter logic.

## Test plan
- Basic program:
  - Stimulus: load AA,BB,CC,DD; addr 0x012345; start. `spi_cmd` model returns status 0x03 then 0x00.
  - Required response: triggers in order WREN(count 1, 0x06), PP(count 8, `cmd_data`[63:0]=0x02012345AABBCCDD), RS, RS. Then one `done` pulse, `status`=0x00, `error`=0, `wr_ready`=1.
- Full page:
  - Stimulus: 256 bytes 0x00..0xFF, then a 257th valid byte.
  - Required response: `wr_ready`=0 after byte 256; 257th byte not accepted. PP count 260, `cmd_data`[2079:2072]=0x02, [7:0]=0xFF.
- Timeout (macro defined, POLL_LIMIT=4):
  - Stimulus: model WIP stuck at 1.
  - Required response: exactly 4 RS transactions, `error`=1 with `done`. Next accepted `start` clears `error`.
- Rejected starts:
  - Stimulus: `start` with 0 bytes loaded; separately, `start` pulsed during PP_WAIT.
  - Required response: no `cmd_trigger`, no state change.
- Reset mid-operation:
  - Stimulus: `reset` low during PP_WAIT.
  - Required response: all outputs at reset values within the same cycle; byte_cnt 0; no further triggers.
- Busy stall:
  - Stimulus: `cmd_busy` high for 3 cycles after start.
  - Required response: `cmd_trigger` delayed until the cycle after `cmd_busy` falls.
